// File: rtl/debug_ocimem_ctrl.sv
// OCI debug RAM plus JTAG monitor address/data registers, arbitrating JTAG and Avalon-MM access.
// Define DEBUG_OCIMEM_PARITY_EN for per-byte even parity on the RAM with a sticky error flag.
module debug_ocimem_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              ocimem_overrun,
    output logic              ocimem_parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DEBUG_OCIMEM_PARITY_EN
    localparam int MEM_W = 36;
`else
    localparam int MEM_W = 32;
`endif

    typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
    typedef enum logic [1:0] {OP_LDA, OP_RDI, OP_WRI} op_t;

    state_t             r_state;
    op_t                r_op;
    logic               r_jtagPend;
    logic               r_ldaRd;
    logic               r_jrdInc;
    logic [ADDR_W-1:0]  r_ldaAddr;
    logic [ADDR_W-1:0]  r_monAReg;
    logic [31:0]        r_wriData;
    logic [31:0]        r_monDReg;
    logic [31:0]        r_readData;
    logic               r_overrun;
    logic [MEM_W-1:0]   r_mem [DEPTH];
    logic [MEM_W-1:0]   r_ramQ;

    logic [3:0]         w_ramWe;
    logic               w_ramRe;
    logic [ADDR_W-1:0]  w_ramAddr;
    logic [31:0]        w_ramWdata;
    logic               w_cpuWrGo;
    logic               w_cpuRdGo;
    logic               w_anyTake;
    logic               w_unusedJdo;

    assign w_unusedJdo = ^{jdo[37:35], jdo[2:0]};
    assign w_anyTake   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_cpuWrGo   = (r_state == IDLE) & ~r_jtagPend & chipselect & write;
    assign w_cpuRdGo   = (r_state == IDLE) & ~r_jtagPend & chipselect & read & ~write;
    assign waitrequest = chipselect & (read | write)
                       & ~((r_state == IDLE) & ~r_jtagPend & write)
                       & (r_state != C_RD);

    assign readdata       = r_readData;
    assign MonDReg        = r_monDReg;
    assign MonAReg        = r_monAReg;
    assign ocimem_overrun = r_overrun;

    // One RAM operation per cycle; a pending JTAG op always takes the port first.
    always_comb begin
        w_ramWe    = 4'b0000;
        w_ramRe    = 1'b0;
        w_ramAddr  = address;
        w_ramWdata = writedata;
        if (r_state == IDLE) begin
            if (r_jtagPend) begin
                case (r_op)
                    OP_LDA: begin
                        w_ramRe   = r_ldaRd;
                        w_ramAddr = r_ldaAddr;
                    end
                    OP_RDI: begin
                        w_ramRe   = 1'b1;
                        w_ramAddr = r_monAReg;
                    end
                    OP_WRI: begin
                        w_ramWe    = 4'b1111;
                        w_ramAddr  = r_monAReg;
                        w_ramWdata = r_wriData;
                    end
                    default: ;
                endcase
            end else if (w_cpuWrGo) begin
                w_ramWe = byteenable;
            end else if (w_cpuRdGo) begin
                w_ramRe = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ramWe[i]) begin
                r_mem[w_ramAddr][8*i +: 8] <= w_ramWdata[8*i +: 8];
`ifdef DEBUG_OCIMEM_PARITY_EN
                r_mem[w_ramAddr][32+i] <= ^w_ramWdata[8*i +: 8];
`endif
            end
        end
        if (w_ramRe) begin
            r_ramQ <= r_mem[w_ramAddr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op       <= OP_LDA;
            r_jtagPend <= 1'b0;
            r_ldaRd    <= 1'b0;
            r_jrdInc   <= 1'b0;
            r_ldaAddr  <= '0;
            r_monAReg  <= ADDR_W'(RESET_ADDR);
            r_wriData  <= '0;
            r_monDReg  <= '0;
            r_readData <= '0;
            r_overrun  <= 1'b0;
        end else begin
            // Only one command can wait; simultaneous pulses resolve WRI > LDA > RDI.
            if (!r_jtagPend) begin
                if (take_action_ocimem_b) begin
                    r_jtagPend <= 1'b1;
                    r_op       <= OP_WRI;
                    r_wriData  <= jdo[34:3];
                    if (take_action_ocimem_a | take_no_action_ocimem_a) r_overrun <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    r_jtagPend <= 1'b1;
                    r_op       <= OP_LDA;
                    r_ldaAddr  <= jdo[25+ADDR_W:26];
                    r_ldaRd    <= jdo[17];
                    if (take_no_action_ocimem_a) r_overrun <= 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    r_jtagPend <= 1'b1;
                    r_op       <= OP_RDI;
                end
            end else if (w_anyTake) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_jtagPend) begin
                        r_jtagPend <= 1'b0;
                        case (r_op)
                            OP_LDA: begin
                                r_monAReg <= r_ldaAddr;
                                if (r_ldaRd) begin
                                    r_jrdInc <= 1'b0;
                                    r_state  <= J_RD;
                                end
                            end
                            OP_RDI: begin
                                r_jrdInc <= 1'b1;
                                r_state  <= J_RD;
                            end
                            OP_WRI:  r_monAReg <= r_monAReg + ADDR_W'(1);
                            default: ;
                        endcase
                    end else if (w_cpuRdGo) begin
                        r_state <= C_RD;
                    end
                end
                J_RD: begin
                    r_monDReg <= r_ramQ[31:0];
                    if (r_jrdInc) r_monAReg <= r_monAReg + ADDR_W'(1);
                    r_state <= IDLE;
                end
                C_RD: begin
                    r_readData <= r_ramQ[31:0];
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DEBUG_OCIMEM_PARITY_EN
    logic r_parityErr;
    logic w_parityBad;

    always_comb begin
        w_parityBad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_ramQ[32+i] != ^r_ramQ[8*i +: 8]) w_parityBad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parityErr <= 1'b0;
        end else if (((r_state == J_RD) || (r_state == C_RD)) && w_parityBad) begin
            r_parityErr <= 1'b1;
        end
    end

    assign ocimem_parity_err = r_parityErr;
`else
    assign ocimem_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Directed self-checking bench for debug_ocimem_ctrl: JTAG ops, CPU access, arbitration, overrun, reset.
module tb_debug_ocimem_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              ocimem_overrun;
    logic              ocimem_parity_err;

    int checkCount = 0;
    int passCount  = 0;

    debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .RESET_ADDR(0)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .ocimem_overrun          (ocimem_overrun),
        .ocimem_parity_err       (ocimem_parity_err)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [37:0] mkLda(input logic [7:0] addr, input logic rd);
        logic [37:0] j;
        j        = '0;
        j[33:26] = addr;
        j[17]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] mkWri(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle take pulse; returns just after the edge that latches it.
    task automatic applyStimulus(input logic a, input logic n, input logic b, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b    = b;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic cpuIdle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic cpuWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = addr;
        writedata  = data;
        byteenable = be;
        tick();
        cpuIdle();
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        address = '0;
        writedata = '0;
        byteenable = '0;
        cpuIdle();
        tick();
        tick();
        checkOutput("rst_monareg", 32'(MonAReg), 32'h0);
        checkOutput("rst_mondreg", MonDReg, 32'h0);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_overrun", 32'(ocimem_overrun), 32'h0);
        checkOutput("rst_waitreq", 32'(waitrequest), 32'h0);
        reset_n = 1'b1;
        tick();

        // LDA without read, then JTAG writes
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'h10, 1'b0));
        tick();
        checkOutput("lda_monareg", 32'(MonAReg), 32'h10);
        checkOutput("lda_noread_mondreg", MonDReg, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'hDEADBEEF));
        tick();
        checkOutput("wri_inc", 32'(MonAReg), 32'h11);
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'h01234567));
        tick();
        checkOutput("wri_inc2", 32'(MonAReg), 32'h12);

        // LDA with read: MonDReg valid 3 clk after the pulse
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'h10, 1'b1));
        tick();
        checkOutput("ldard_early", MonDReg, 32'h0);
        tick();
        checkOutput("ldard_data", MonDReg, 32'hDEADBEEF);
        checkOutput("ldard_addr", 32'(MonAReg), 32'h10);

        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        tick();
        checkOutput("rdi1_data", MonDReg, 32'hDEADBEEF);
        checkOutput("rdi1_addr", 32'(MonAReg), 32'h11);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        tick();
        checkOutput("rdi2_data", MonDReg, 32'h01234567);
        checkOutput("rdi2_addr", 32'(MonAReg), 32'h12);

        // Address wrap at the top of the RAM
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'hFF, 1'b0));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'hCAFEF00D));
        tick();
        checkOutput("wri_wrap", 32'(MonAReg), 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'hFF, 1'b1));
        tick();
        tick();
        checkOutput("wrap_data", MonDReg, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        tick();
        checkOutput("rdi_wrap", 32'(MonAReg), 32'h00);

        // CPU byte-enabled write then read
        chipselect = 1'b1;
        write = 1'b1;
        address = 8'h20;
        writedata = 32'hAABBCCDD;
        byteenable = 4'b1111;
        #1;
        checkOutput("cpuwr_nowait", 32'(waitrequest), 32'h0);
        tick();
        cpuIdle();
        cpuWrite(8'h20, 32'h12345678, 4'b0011);
        chipselect = 1'b1;
        read = 1'b1;
        address = 8'h20;
        #1;
        checkOutput("cpurd_wait", 32'(waitrequest), 32'h1);
        tick();
        checkOutput("cpurd_release", 32'(waitrequest), 32'h0);
        tick();
        cpuIdle();
        checkOutput("cpurd_data", readdata, 32'hAABB5678);

        // CPU read arriving while a JTAG write is pending is delayed one cycle
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'h40, 1'b0));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'h55AA55AA));
        chipselect = 1'b1;
        read = 1'b1;
        address = 8'h40;
        #1;
        checkOutput("arb_stall_pend", 32'(waitrequest), 32'h1);
        tick();
        checkOutput("arb_jtag_first", 32'(MonAReg), 32'h41);
        checkOutput("arb_stall_issue", 32'(waitrequest), 32'h1);
        tick();
        checkOutput("arb_release", 32'(waitrequest), 32'h0);
        tick();
        cpuIdle();
        checkOutput("arb_data", readdata, 32'h55AA55AA);
        checkOutput("overrun_clear", 32'(ocimem_overrun), 32'h0);

        // Second WRI while the first is pending is dropped
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'h77777777));
        applyStimulus(1'b0, 1'b0, 1'b1, mkWri(32'h88888888));
        tick();
        tick();
        checkOutput("overrun_set", 32'(ocimem_overrun), 32'h1);
        checkOutput("overrun_drop_addr", 32'(MonAReg), 32'h42);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'h41, 1'b1));
        tick();
        tick();
        checkOutput("overrun_first_kept", MonDReg, 32'h77777777);

        // Parity check on a CPU read of 0x30
        cpuWrite(8'h30, 32'h0F0F0F0F, 4'b1111);
`ifdef DEBUG_OCIMEM_PARITY_EN
        dut.r_mem[8'h30][32] = ~dut.r_mem[8'h30][32];
`endif
        chipselect = 1'b1;
        read = 1'b1;
        address = 8'h30;
        tick();
        tick();
        cpuIdle();
        checkOutput("par_data", readdata, 32'h0F0F0F0F);
`ifdef DEBUG_OCIMEM_PARITY_EN
        checkOutput("par_err_set", 32'(ocimem_parity_err), 32'h1);
        tick();
        tick();
        checkOutput("par_err_sticky", 32'(ocimem_parity_err), 32'h1);
`else
        checkOutput("par_err_tied", 32'(ocimem_parity_err), 32'h0);
`endif

        // Mid-sequence reset clears everything
        reset_n = 1'b0;
        #1;
        checkOutput("rst2_monareg", 32'(MonAReg), 32'h0);
        checkOutput("rst2_mondreg", MonDReg, 32'h0);
        checkOutput("rst2_readdata", readdata, 32'h0);
        checkOutput("rst2_overrun", 32'(ocimem_overrun), 32'h0);
        checkOutput("rst2_parity", 32'(ocimem_parity_err), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Simultaneous LDA and WRI: WRI wins, LDA dropped
        applyStimulus(1'b1, 1'b0, 1'b1, mkWri(32'h11223344));
        tick();
        checkOutput("prio_wri_addr", 32'(MonAReg), 32'h01);
        checkOutput("prio_overrun", 32'(ocimem_overrun), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, mkLda(8'h00, 1'b1));
        tick();
        tick();
        checkOutput("prio_wri_data", MonDReg, 32'h11223344);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
